// File: rtl/regfile_scan_ctrl_pkg.sv
// Shared definitions for the register-file scan sequencer: default geometry,
// the scan state encoding and the first-register helper.
package regfile_scan_ctrl_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DUMP  = 2'd2
  } scan_state_e;

  // r0 is hardwired in the MIPS regfile, so scans normally begin at r1.
  function automatic int scan_first(input bit skip_r0);
    return skip_r0 ? 1 : 0;
  endfunction

endpackage

// File: rtl/regfile_scan_ctrl_if.sv
// Bundle of the regfile ports (read port 1, write port 3) and the dump stream.
// The sequencer is the master; the regfile plus the dump consumer form the slave.
interface regfile_scan_ctrl_if
  import regfile_scan_ctrl_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
);

  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] A1;
  logic [DW-1:0] RD1;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;

  modport master (
    output WE3, A3, WD3, A1, dump_valid, dump_addr, dump_data,
    input  RD1, dump_ready
  );

  modport slave (
    input  WE3, A3, WD3, A1, dump_valid, dump_addr, dump_data,
    output RD1, dump_ready
  );

endinterface

// File: rtl/regfile_scan_ctrl.sv
// Initiator-side sequencer for the 3-port register file. CLEAR writes
// CLEAR_VALUE to every scanned register, one per cycle. DUMP reads every
// scanned register through port 1 and streams {addr,data} beats on a
// valid/ready interface with full throughput and stable data under stall.
module regfile_scan_ctrl
  import regfile_scan_ctrl_pkg::*;
#(
  parameter int            NREGS       = RF_NREGS,
  parameter int            AW          = RF_AW,
  parameter int            DW          = RF_DW,
  parameter logic [DW-1:0] CLEAR_VALUE = '0,
  parameter bit            SKIP_R0     = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_clear,
  input  logic                start_dump,
  output logic                busy,
  output logic                done,
  regfile_scan_ctrl_if.master bus
);

  // Scan range; termination compares against LAST so pointers never wrap.
  localparam logic [AW-1:0] FIRST = AW'(scan_first(SKIP_R0));
  localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

  scan_state_e   r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_issued;
  logic          r_dump_valid;
  logic [AW-1:0] r_dump_addr;
  logic [DW-1:0] r_dump_data;
  logic          r_done;

  scan_state_e   w_state_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic          w_issued_nxt;
  logic          w_dump_valid_nxt;
  logic [AW-1:0] w_dump_addr_nxt;
  logic [DW-1:0] w_dump_data_nxt;
  logic          w_done_nxt;
  logic          w_load;

  // A new beat may be captured when reads remain and the output slot is
  // empty or is being emptied by a handshake in this same cycle.
  assign w_load = !r_issued && (!r_dump_valid || bus.dump_ready);

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  // Gating with reset keeps the regfile from taking a write on the very edge
  // that aborts the scan, so registers not yet reached keep their contents.
  assign bus.WE3 = (r_state == ST_CLEAR) && !reset;
  assign bus.A3  = r_wr_ptr;
  assign bus.WD3 = CLEAR_VALUE;
  assign bus.A1  = r_rd_ptr;

  assign bus.dump_valid = r_dump_valid;
  assign bus.dump_addr  = r_dump_addr;
  assign bus.dump_data  = r_dump_data;

  // Next-state, pointer and dump-slot logic; everything holds unless changed.
  always_comb begin
    w_state_nxt      = r_state;
    w_wr_ptr_nxt     = r_wr_ptr;
    w_rd_ptr_nxt     = r_rd_ptr;
    w_issued_nxt     = r_issued;
    w_dump_valid_nxt = r_dump_valid;
    w_dump_addr_nxt  = r_dump_addr;
    w_dump_data_nxt  = r_dump_data;
    w_done_nxt       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // CLEAR has priority; a simultaneous dump request is dropped.
        if (start_clear) begin
          w_state_nxt  = ST_CLEAR;
          w_wr_ptr_nxt = FIRST;
        end else if (start_dump) begin
          w_state_nxt  = ST_DUMP;
          w_rd_ptr_nxt = FIRST;
          w_issued_nxt = 1'b0;
        end
      end

      ST_CLEAR: begin
        if (r_wr_ptr == LAST) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_wr_ptr_nxt = r_wr_ptr + AW'(1);
        end
      end

      ST_DUMP: begin
        if (w_load) begin
          w_dump_valid_nxt = 1'b1;
          w_dump_addr_nxt  = r_rd_ptr;
          w_dump_data_nxt  = bus.RD1;
          if (r_rd_ptr == LAST) begin
            w_issued_nxt = 1'b1;
          end else begin
            w_rd_ptr_nxt = r_rd_ptr + AW'(1);
          end
        end else if (r_issued && r_dump_valid && bus.dump_ready) begin
          w_dump_valid_nxt = 1'b0;
          w_done_nxt       = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any scan without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_issued     <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= '0;
      r_dump_data  <= '0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_issued     <= w_issued_nxt;
      r_dump_valid <= w_dump_valid_nxt;
      r_dump_addr  <= w_dump_addr_nxt;
      r_dump_data  <= w_dump_data_nxt;
      r_done       <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// Scoreboard bench for regfile_scan_ctrl: a behavioural register file, a
// shadow copy of its expected contents, and queues of expected clear
// addresses and dump beats consumed by independent monitors.
`timescale 1ns/1ps
module tb_regfile_scan_ctrl;
  import regfile_scan_ctrl_pkg::*;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk;
  logic reset, start_clear, start_dump, busy, done;
  logic start_clear0, busy0, done0;
  logic ready;
  logic          tb_we;
  logic [AW-1:0] tb_wa;
  logic [DW-1:0] tb_wd;

  logic [DW-1:0] rf     [NREGS];
  logic [DW-1:0] rf0    [NREGS];
  logic [DW-1:0] shadow [NREGS];

  logic [AW+DW-1:0] exp_q[$];
  logic [AW-1:0]    clr_q[$];
  logic [AW-1:0]    clr0_q[$];

  int checks = 0;
  int errors = 0;
  int hs_cnt, busy_cnt, busy0_cnt, we0_cnt;
  bit done_due  = 0;
  bit done0_due = 0;
  bit stall_pend = 0;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;

  regfile_scan_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  regfile_scan_ctrl_if #(.AW(AW), .DW(DW)) bus0 ();

  regfile_scan_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW), .CLEAR_VALUE(32'h0), .SKIP_R0(1'b1)) dut (
    .clk(clk), .reset(reset), .start_clear(start_clear), .start_dump(start_dump),
    .busy(busy), .done(done), .bus(bus)
  );

  regfile_scan_ctrl #(.NREGS(NREGS), .AW(AW), .DW(DW), .CLEAR_VALUE(32'h0), .SKIP_R0(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start_clear(start_clear0), .start_dump(1'b0),
    .busy(busy0), .done(done0), .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register files; r0 of the main one reads as zero.
  always @(posedge clk) begin
    if (bus.WE3) rf[bus.A3] <= bus.WD3;
    else if (tb_we) rf[tb_wa] <= tb_wd;
  end
  always @(posedge clk) begin
    if (bus0.WE3) rf0[bus0.A3] <= bus0.WD3;
    else if (tb_we) rf0[tb_wa] <= tb_wd;
  end
  assign bus.RD1         = (bus.A1 == '0) ? '0 : rf[bus.A1];
  assign bus.dump_ready  = ready;
  assign bus0.RD1        = rf0[bus0.A1];
  assign bus0.dump_ready = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: r[i]=i*01010101, 1: all A5A5A5A5, else random
  task automatic preload(input int mode);
    logic [DW-1:0] v;
    for (int i = 0; i < NREGS; i++) begin
      case (mode)
        0:       v = i * 32'h01010101;
        1:       v = 32'hA5A5A5A5;
        default: v = $urandom();
      endcase
      tb_we = 1'b1; tb_wa = AW'(i); tb_wd = v;
      shadow[i] = (i == 0) ? '0 : v;
      tick();
    end
    tb_we = 1'b0;
  endtask

  task automatic push_dump();
    for (int a = 1; a < NREGS; a++) exp_q.push_back({AW'(a), shadow[a]});
  endtask

  task automatic push_clear();
    for (int a = 1; a < NREGS; a++) clr_q.push_back(AW'(a));
  endtask

  // mode 0: ready held high, 1: toggling 1,0,1,0, else random
  task automatic run_until_idle(input string nm, input int mode, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || clr_q.size() != 0 || busy) && n < max_cyc) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ~ready;
        default: ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    if (n >= max_cyc) begin
      chk({nm, "_timeout"}, 1, 0);
      exp_q.delete();
      clr_q.delete();
    end
    ready = 1'b0;
    tick();
  endtask

  task automatic check_rf(input string nm);
    int bad = 0;
    for (int i = 1; i < NREGS; i++) if (rf[i] !== shadow[i]) bad++;
    chk(nm, bad, 0);
  endtask

  task automatic pulse_dump();
    start_dump = 1'b1; tick(); start_dump = 1'b0;
  endtask

  // Monitor for the main instance: clear writes, dump beats, stalls, done.
  initial begin
    logic [AW-1:0]    a;
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      chk("done_pulse", done, done_due);
      done_due = 0;
      if (busy) busy_cnt++;
      if (!reset) begin
        if (stall_pend && bus.dump_valid) begin
          chk("stall_addr", bus.dump_addr, st_addr);
          chk("stall_data", bus.dump_data, st_data);
        end
        if (bus.WE3) begin
          chk("clr_wd3", bus.WD3, 0);
          if (clr_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            a = clr_q.pop_front();
            chk("clr_a3", bus.A3, a);
            if (clr_q.size() == 0) done_due = 1;
          end
        end
        if (bus.dump_valid && ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_addr", bus.dump_addr, e[AW+DW-1:DW]);
            chk("beat_data", bus.dump_data, e[DW-1:0]);
            if (exp_q.size() == 0) done_due = 1;
          end
        end
        stall_pend = bus.dump_valid && !ready;
        st_addr = bus.dump_addr;
        st_data = bus.dump_data;
      end else begin
        stall_pend = 0;
      end
    end
  end

  // Monitor for the SKIP_R0=0 instance: clear writes and done.
  initial begin
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      chk("done0_pulse", done0, done0_due);
      done0_due = 0;
      if (busy0) busy0_cnt++;
      if (!reset && bus0.WE3) begin
        we0_cnt++;
        if (clr0_q.size() == 0) chk("unexpected_write0", 1, 0);
        else begin
          a = clr0_q.pop_front();
          chk("clr0_a3", bus0.A3, a);
          if (clr0_q.size() == 0) done0_due = 1;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    reset = 1'b1; start_clear = 1'b0; start_dump = 1'b0; start_clear0 = 1'b0;
    ready = 1'b0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (3) tick();
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_we3",   bus.WE3, 0);
    chk("rst_a3",    bus.A3, 0);
    chk("rst_a1",    bus.A1, 0);
    chk("rst_dv",    bus.dump_valid, 0);
    chk("rst_daddr", bus.dump_addr, 0);
    chk("rst_ddata", bus.dump_data, 0);
    reset = 1'b0;
    tick();

    // CLEAR on the instance that includes r0
    preload(2);
    tb_we = 1'b1; tb_wa = 5'd5; tb_wd = 32'hDEADBEEF; shadow[5] = 32'hDEADBEEF; tick(); tb_we = 1'b0;
    for (int a = 0; a < NREGS; a++) clr0_q.push_back(AW'(a));
    busy0_cnt = 0; we0_cnt = 0;
    start_clear0 = 1'b1; tick(); start_clear0 = 1'b0;
    n = 0;
    while ((clr0_q.size() != 0 || busy0) && n < 200) begin tick(); n++; end
    if (n >= 200) begin chk("t1_timeout", 1, 0); clr0_q.delete(); end
    tick();
    chk("t1_we_cycles", we0_cnt, 32);
    chk("t1_busy_cycles", busy0_cnt, 32);
    chk("t1_busy", busy0, 0);
    chk("t1_r5", rf0[5], 0);
    bad = 0;
    for (int i = 0; i < NREGS; i++) if (rf0[i] !== 32'h0) bad++;
    chk("t1_all_zero", bad, 0);

    // DUMP at full throughput
    preload(0);
    push_dump();
    busy_cnt = 0; hs_cnt = 0;
    pulse_dump();
    run_until_idle("t2", 0, 200);
    chk("t2_beats", hs_cnt, 31);
    chk("t2_busy_cycles", busy_cnt, 32);

    // DUMP with ready toggling 1,0,1,0
    push_dump();
    hs_cnt = 0;
    pulse_dump();
    run_until_idle("t3", 1, 400);
    chk("t3_beats", hs_cnt, 31);

    // DUMP of random contents with random backpressure
    preload(2);
    push_dump();
    hs_cnt = 0;
    pulse_dump();
    run_until_idle("t3r", 2, 400);
    chk("t3r_beats", hs_cnt, 31);

    // Simultaneous starts, then a dump request during CLEAR
    preload(2);
    push_clear();
    busy_cnt = 0; hs_cnt = 0;
    start_clear = 1'b1; start_dump = 1'b1; tick(); start_clear = 1'b0; start_dump = 1'b0;
    repeat (5) tick();
    pulse_dump();
    run_until_idle("t4", 0, 200);
    chk("t4_busy_cycles", busy_cnt, 31);
    chk("t4_no_beats", hs_cnt, 0);
    for (int i = 1; i < NREGS; i++) shadow[i] = '0;
    check_rf("t4_rf");
    push_dump();
    hs_cnt = 0;
    pulse_dump();
    run_until_idle("t4d", 2, 400);
    chk("t4d_beats", hs_cnt, 31);

    // Reset in the middle of CLEAR
    preload(1);
    push_clear();
    start_clear = 1'b1; tick(); start_clear = 1'b0;
    n = 0;
    while (bus.A3 != 5'd10 && n < 100) begin tick(); n++; end
    if (n >= 100) chk("t5_timeout", 1, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    clr_q.delete();
    chk("t5_we3", bus.WE3, 0);
    chk("t5_busy", busy, 0);
    for (int i = 1; i < 10; i++) shadow[i] = '0;
    repeat (3) tick();
    chk("t5_r9", rf[9], 32'h0);
    chk("t5_r10", rf[10], 32'hA5A5A5A5);
    check_rf("t5_rf");

    // Reset while a beat is stalled, then restart
    preload(2);
    push_dump();
    ready = 1'b0;
    pulse_dump();
    n = 0;
    while (!bus.dump_valid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("t6_timeout", 1, 0);
    repeat (2) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    exp_q.delete();
    chk("t6_dv", bus.dump_valid, 0);
    chk("t6_busy", busy, 0);
    push_dump();
    hs_cnt = 0;
    pulse_dump();
    run_until_idle("t6r", 2, 400);
    chk("t6r_beats", hs_cnt, 31);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
